ascon_sram_fifo_ctrl: RTL and testbench



---
 rtl/ascon_sram_pkg.sv | 16 +
 rtl/ascon_sram_fifo_ctrl_if.sv | 31 +++
 rtl/ascon_sram_obuf.sv | 41 ++++
 rtl/ascon_sram_fifo_ctrl.sv | 88 ++++++++
 tb/tb_ascon_sram_fifo_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ascon_sram_pkg.sv
// Shared parameters and types for the ASCON SRAM-backed FIFO controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ascon_sram_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  // The read credit scheme assumes exactly two landing slots.
  localparam int OBUF_DEPTH = 2;

  typedef logic [ADDR_WIDTH-1:0] sram_addr_t;
  typedef logic [DATA_WIDTH-1:0] sram_word_t;
  typedef logic [ADDR_WIDTH+1:0] fifo_level_t;

endpackage

// File: rtl/ascon_sram_fifo_ctrl_if.sv
// Push/pop stream bundle for the SRAM FIFO controller, plus its fill level.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the push and pop sides.
interface ascon_sram_fifo_ctrl_if
  import ascon_sram_pkg::*;
#(
  parameter int DATA_WIDTH = ascon_sram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ascon_sram_pkg::ADDR_WIDTH
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH+1:0] level;

  // Producer/consumer side (drives pushes, accepts pops).
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level
  );

  // FIFO side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level
  );

endinterface

// File: rtl/ascon_sram_obuf.sv
// Two-entry register FIFO that lands SRAM read data and presents the pop head.
// Latency: captured word is visible at the head the cycle after capture.
// Backpressure: none internally; the parent only captures when a slot is guaranteed free.
module ascon_sram_obuf
  import ascon_sram_pkg::*;
#(
  parameter int WIDTH = ascon_sram_pkg::DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap,
  input  logic [WIDTH-1:0] cap_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] ent [OBUF_DEPTH];
  logic             head;
  logic             tail;

  assign head_data = ent[head];

  // Ring of two slots: capture writes at tail, pop advances head.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < OBUF_DEPTH; i++) ent[i] <= '0;
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (cap) begin
        ent[tail] <= cap_data;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      count <= count + {1'b0, cap} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/ascon_sram_fifo_ctrl.sv
// Runs a 1R1W SRAM macro as a FIFO with a 2-entry output buffer hiding the read latency.
// Latency: push at edge N -> read issued at edge N+1 -> out_valid at edge N+2.
// Backpressure: in_ready drops only when the macro is full; reads are issued on credit only.
module ascon_sram_fifo_ctrl
  import ascon_sram_pkg::*;
#(
  parameter int DATA_WIDTH = ascon_sram_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = ascon_sram_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  ascon_sram_fifo_ctrl_if.slave bus,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam int DEPTH_P = 1 << ADDR_WIDTH;
  localparam int LW      = ADDR_WIDTH + 2;

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   mem_cnt;
  logic                  rd_inflight;
  logic [1:0]            obuf_cnt;
  logic                  push;
  logic                  issue;
  logic                  pop;
  logic                  credit_ok;

  assign bus.in_ready  = (mem_cnt != (ADDR_WIDTH+1)'(DEPTH_P));
  assign bus.out_valid = (obuf_cnt != 2'd0);
  assign pop           = bus.out_valid & bus.out_ready;
  assign push          = bus.in_valid & bus.in_ready & ~rst;

  // credit = 2 - obuf_cnt - rd_inflight + pop > 0, rearranged to stay unsigned.
  assign credit_ok = ({1'b0, obuf_cnt} + {2'b00, rd_inflight}) < (3'd2 + {2'b00, pop});
  assign issue     = (mem_cnt != '0) & credit_ok & ~rst;

  // Macro strobes; address/data are held at the pointer and input word when idle.
  assign sram_csb0  = ~push;
  assign sram_addr0 = wptr;
  assign sram_din0  = bus.in_data;
  assign sram_csb1  = ~issue;
  assign sram_addr1 = rptr;

  assign bus.level = LW'(mem_cnt) + LW'(rd_inflight) + LW'(obuf_cnt);

  // Pointer, occupancy and in-flight tracking; a reset drops any pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      mem_cnt     <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (push)  wptr <= wptr + 1'b1;
      if (issue) rptr <= rptr + 1'b1;
      rd_inflight <= issue;
      case ({push, issue})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase
    end
  end

  // Read data is valid only at the edge after issue, so capture is keyed on rd_inflight.
  ascon_sram_obuf #(
    .WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk       (clk),
    .rst       (rst),
    .cap       (rd_inflight),
    .cap_data  (sram_dout1),
    .pop       (pop),
    .count     (obuf_cnt),
    .head_data (bus.out_data)
  );

  // Pointers only meet when the macro is empty or full, so both ports never hit one word.
  addr_collision: assert property (@(posedge clk) disable iff (rst)
    !(!sram_csb0 && !sram_csb1 && (sram_addr0 == sram_addr1)));

endmodule

// File: tb/tb_ascon_sram_fifo_ctrl.sv
// Self-checking bench for ascon_sram_fifo_ctrl with a behavioural SRAM macro model.
// Reference: a queue of accepted-but-not-popped words; level must equal its size.
// Inputs driven on the falling edge, outputs sampled 1ns later.
module tb_ascon_sram_fifo_ctrl;
  import ascon_sram_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sram_csb0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout1;
  logic [DW-1:0] macro [1<<AW];

  int total = 0;
  int bad   = 0;

  ascon_sram_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ascon_sram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_csb0  (sram_csb0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  always #5 clk = ~clk;

  // Macro model: inputs registered at the edge, read data good until the following edge only.
  always @(posedge clk) begin
    if (!sram_csb0) macro[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= macro[sram_addr1];
    else            sram_dout1 <= 'x;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock: drive on the falling edge, report which handshakes the next rising edge takes.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r,
                       output logic pushed, output logic popped, output logic [DW-1:0] pdata);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    pushed = v & bus.in_ready;
    popped = bus.out_valid & r;
    pdata  = bus.out_data;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.level !== '0) begin bad++; $display("FAIL reset_level got=%0d want=0", bus.level); end
    total++; if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1) begin bad++; $display("FAIL reset_csb got=%b%b want=11", sram_csb0, sram_csb1); end
    total++; if (bus.out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%h want=0", bus.out_data); end
  endtask

  // Push taken at edge E0; csb1 low before E1; out_valid visible after E2; popped at E3.
  task automatic test_single();
    logic p, o; logic [DW-1:0] d;
    cycle(1'b1, 32'hDEADBEEF, 1'b1, p, o, d);
    total++; if (p !== 1'b1) begin bad++; $display("FAIL single_push got=%b want=1", p); end
    cycle(1'b0, '0, 1'b1, p, o, d);
    total++; if (sram_csb1 !== 1'b0 || sram_addr1 !== '0) begin bad++; $display("FAIL single_issue csb1=%b addr1=%0d want 0/0", sram_csb1, sram_addr1); end
    total++; if (bus.level !== 7'd1) begin bad++; $display("FAIL single_level1 got=%0d want=1", bus.level); end
    cycle(1'b0, '0, 1'b1, p, o, d);
    total++; if (bus.out_valid !== 1'b0 || bus.level !== 7'd1) begin bad++; $display("FAIL single_inflight valid=%b level=%0d want 0/1", bus.out_valid, bus.level); end
    cycle(1'b0, '0, 1'b1, p, o, d);
    total++; if (o !== 1'b1 || d !== 32'hDEADBEEF) begin bad++; $display("FAIL single_out valid=%b data=%h want 1/deadbeef", o, d); end
    cycle(1'b0, '0, 1'b1, p, o, d);
    total++; if (bus.level !== '0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_empty level=%0d valid=%b want 0/0", bus.level, bus.out_valid); end
  endtask

  task automatic test_fill_drain();
    logic p, o; logic [DW-1:0] d;
    int acc = 0, full_at = -1, got = 0, last = -1, gaps = 0;
    for (int c = 0; c < 60; c++) begin
      cycle(acc <= 40, DW'(acc), 1'b0, p, o, d);
      if (full_at < 0 && !bus.in_ready) full_at = acc;
      if (p) acc++;
    end
    total++; if (full_at !== 34) begin bad++; $display("FAIL fill_ready_drop after=%0d want=34", full_at); end
    total++; if (acc !== 34) begin bad++; $display("FAIL fill_accepts got=%0d want=34", acc); end
    total++; if (bus.level !== 7'd34) begin bad++; $display("FAIL fill_level got=%0d want=34", bus.level); end
    for (int c = 0; c < 100 && got < 34; c++) begin
      cycle(1'b0, '0, 1'b1, p, o, d);
      if (o) begin
        total++; if (d !== DW'(got)) begin bad++; $display("FAIL drain_data idx=%0d got=%0d want=%0d", got, d, got); end
        if (last >= 0 && c != last + 1) gaps++;
        last = c;
        got++;
      end
    end
    total++; if (got !== 34 || gaps !== 0) begin bad++; $display("FAIL drain_count got=%0d gaps=%0d want 34/0", got, gaps); end
    cycle(1'b0, '0, 1'b0, p, o, d);
    total++; if (bus.level !== '0) begin bad++; $display("FAIL drain_level got=%0d want=0", bus.level); end
  endtask

  task automatic test_stream();
    logic p, o; logic [DW-1:0] d;
    int sent = 0, rcvd = 0, first_push = -1, first_pop = -1, stalls = 0, bubbles = 0;
    for (int c = 0; c < 400 && rcvd < 200; c++) begin
      cycle(sent < 200, DW'(sent) + 32'h1000, 1'b1, p, o, d);
      if (sent < 200 && !p) stalls++;
      if (p) begin
        if (first_push < 0) first_push = c;
        sent++;
      end
      if (o) begin
        if (first_pop < 0) first_pop = c;
        if (c != first_pop + rcvd) bubbles++;
        total++; if (d !== DW'(rcvd) + 32'h1000) begin bad++; $display("FAIL stream_data idx=%0d got=%h want=%h", rcvd, d, DW'(rcvd) + 32'h1000); end
        rcvd++;
      end
    end
    total++; if (rcvd !== 200) begin bad++; $display("FAIL stream_count got=%0d want=200", rcvd); end
    total++; if (stalls !== 0) begin bad++; $display("FAIL stream_stalls got=%0d want=0", stalls); end
    total++; if (bubbles !== 0) begin bad++; $display("FAIL stream_bubbles got=%0d want=0", bubbles); end
    total++; if (first_pop - first_push !== 3) begin bad++; $display("FAIL stream_fill got=%0d want=3", first_pop - first_push); end
  endtask

  task automatic test_random();
    logic p, o; logic [DW-1:0] d, w, exp;
    logic [DW-1:0] q [$];
    int sent = 0, rcvd = 0;
    for (int c = 0; c < 10000 && rcvd < 1000; c++) begin
      w = $urandom;
      cycle((sent < 1000) && ($urandom_range(0, 1) == 1), w, $urandom_range(0, 1) == 1, p, o, d);
      total++; if (bus.level !== 7'(q.size())) begin bad++; $display("FAIL rand_level cyc=%0d got=%0d want=%0d", c, bus.level, q.size()); end
      if (!sram_csb0 && !sram_csb1) begin
        total++; if (sram_addr0 === sram_addr1) begin bad++; $display("FAIL rand_collision addr=%0d want distinct", sram_addr0); end
      end
      if (p) begin q.push_back(w); sent++; end
      if (o) begin
        exp = (q.size() != 0) ? q.pop_front() : 'x;
        total++; if (d !== exp) begin bad++; $display("FAIL rand_data idx=%0d got=%h want=%h", rcvd, d, exp); end
        rcvd++;
      end
    end
    total++; if (rcvd !== 1000) begin bad++; $display("FAIL rand_count got=%0d want=1000", rcvd); end
  endtask

  task automatic test_reset_inflight();
    logic p, o; logic [DW-1:0] d;
    int found = 0;
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'hA0 + DW'(i), 1'b0, p, o, d);
    repeat (3) cycle(1'b0, '0, 1'b0, p, o, d);
    total++; if (bus.level !== 7'd5) begin bad++; $display("FAIL rst_held_level got=%0d want=5", bus.level); end
    cycle(1'b0, '0, 1'b1, p, o, d);
    total++; if (o !== 1'b1 || sram_csb1 !== 1'b0) begin bad++; $display("FAIL rst_pre_issue pop=%b csb1=%b want 1/0", o, sram_csb1); end
    @(negedge clk);
    rst = 1'b1; bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0 || bus.level !== '0) begin bad++; $display("FAIL rst_flush valid=%b level=%0d want 0/0", bus.out_valid, bus.level); end
    total++; if ($isunknown(bus.out_data) || bus.out_data !== '0) begin bad++; $display("FAIL rst_out_data got=%h want=0", bus.out_data); end
    cycle(1'b1, 32'h1234, 1'b1, p, o, d);
    for (int c = 0; c < 10; c++) begin
      cycle(1'b0, '0, 1'b1, p, o, d);
      if (o) begin
        found++;
        total++; if (d !== 32'h1234) begin bad++; $display("FAIL rst_repush_data got=%h want=1234", d); end
      end
    end
    total++; if (found !== 1) begin bad++; $display("FAIL rst_repush_count got=%0d want=1", found); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_stream();
    test_random();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
